// File: rtl/braid_input_dispenser_if.sv
// braid_input_dispenser_if: host request handshake into the braid input dispenser
//   req_valid  host request strobe
//   req_ready  dispenser can accept a request
//   req_chan   target braid input index
//   req_doses  number of doses to dispense
interface braid_input_dispenser_if #(
  parameter int CHAN_W = 2,
  parameter int DOSE_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [CHAN_W-1:0] req_chan;
  logic [DOSE_W-1:0] req_doses;
  modport master (output req_valid, req_chan, req_doses, input req_ready);
  modport slave  (input req_valid, req_chan, req_doses, output req_ready);
endinterface

// File: rtl/braid_input_dispenser.sv
// braid_input_dispenser: meters fluid doses into braid inputs, one valve open at a time
//   clk, rst_n  clock, asynchronous active-low reset
//   req         request handshake (slave side of braid_input_dispenser_if)
//   valve_open  one-hot valve drive, zero when no dose is active
//   busy        FSM active or requests queued
//   done_pulse  one-cycle strobe when a request completes
//   dose_total  saturating count of completed doses
//   fifo_level  request queue occupancy
// Optional: BRAID_DISPENSE_PRIME_EN adds a one-time priming pulse per channel.
module braid_input_dispenser #(
  parameter int NUM_INPUTS    = 4,
  parameter int CHAN_W        = 2,
  parameter int DOSE_W        = 8,
  parameter int PULSE_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int PRIME_CYCLES  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  braid_input_dispenser_if.slave        req,
  output logic [NUM_INPUTS-1:0]         valve_open,
  output logic                          busy,
  output logic                          done_pulse,
  output logic [15:0]                   dose_total,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CNT_MAX = PRIME_CYCLES > PULSE_CYCLES ?
                           (PRIME_CYCLES > SETTLE_CYCLES ? PRIME_CYCLES : SETTLE_CYCLES) :
                           (PULSE_CYCLES > SETTLE_CYCLES ? PULSE_CYCLES : SETTLE_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  typedef enum logic [2:0] {
    IDLE, LOAD, PULSE, SETTLE, DONE
`ifdef BRAID_DISPENSE_PRIME_EN
    , PRIME
`endif
  } state_t;
  state_t            state, state_n;
  logic [CHAN_W-1:0] mem_chan  [FIFO_DEPTH];
  logic [DOSE_W-1:0] mem_doses [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [LW-1:0]     level;
  logic              ready_en, push, pop, empty, active, priming;
  logic [CHAN_W-1:0] chan_r;
  logic [DOSE_W-1:0] remaining_r;
  logic [CNT_W-1:0]  cnt;
  logic              last_pulse, last_settle;
  assign empty       = level == '0;
  // ready_en keeps req_ready low until the first edge after reset release
  assign req.req_ready = ready_en && level != LW'(FIFO_DEPTH);
  // out-of-range channels complete the handshake but never enter the queue
  assign push        = req.req_valid && req.req_ready && 32'(req.req_chan) < NUM_INPUTS;
  assign pop         = state == LOAD;
  assign last_pulse  = cnt == CNT_W'(PULSE_CYCLES - 1);
  assign last_settle = cnt == CNT_W'(SETTLE_CYCLES - 1);
  assign busy        = state != IDLE || !empty;
  assign done_pulse  = state == DONE;
  assign fifo_level  = level;
  assign valve_open  = active ? NUM_INPUTS'(1) << chan_r : '0;
`ifdef BRAID_DISPENSE_PRIME_EN
  logic [NUM_INPUTS-1:0] primed;
  logic                  priming_r;
  logic                  last_prime;
  assign last_prime = cnt == CNT_W'(PRIME_CYCLES - 1);
  assign priming    = priming_r;
  assign active     = state == PULSE || state == PRIME;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      primed    <= '0;
      priming_r <= 1'b0;
    end else begin
      if (state == LOAD) priming_r <= state_n == PRIME;
      if (state == SETTLE && last_settle && priming_r) begin
        primed[chan_r] <= 1'b1;
        priming_r      <= 1'b0;
      end
    end
`else
  assign priming = 1'b0;
  assign active  = state == PULSE;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = empty ? IDLE : LOAD;
`ifdef BRAID_DISPENSE_PRIME_EN
      LOAD:   state_n = mem_doses[rp] == '0 ? DONE : !primed[mem_chan[rp]] ? PRIME : PULSE;
      PRIME:  state_n = last_prime ? SETTLE : PRIME;
`else
      LOAD:   state_n = mem_doses[rp] == '0 ? DONE : PULSE;
`endif
      PULSE:  state_n = last_pulse ? SETTLE : PULSE;
      // a priming settle leaves remaining untouched, so dosing always follows
      SETTLE: state_n = !last_settle ? SETTLE :
                        (priming || remaining_r != DOSE_W'(1)) ? PULSE : DONE;
      DONE:   state_n = empty ? IDLE : LOAD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      ready_en    <= 1'b0;
      cnt         <= '0;
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      chan_r      <= '0;
      remaining_r <= '0;
      dose_total  <= '0;
    end else begin
      state    <= state_n;
      ready_en <= 1'b1;
      cnt      <= state_n != state ? '0 : cnt + 1'b1;
      wp       <= wp + PW'(push);
      rp       <= rp + PW'(pop);
      level    <= level + LW'(push) - LW'(pop);
      if (pop) begin
        chan_r      <= mem_chan[rp];
        remaining_r <= mem_doses[rp];
      end
      if (state == SETTLE && last_settle && !priming) begin
        remaining_r <= remaining_r - 1'b1;
        dose_total  <= dose_total + 16'(dose_total != 16'hFFFF);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_chan[wp]  <= req.req_chan;
      mem_doses[wp] <= req.req_doses;
    end
endmodule
